multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  high = keep issuing instructions; low = stop at the next instruction boundary.
REQ-005 opcode  input  11  instruction bits [31:21] from the datapath instruction register.
REQ-006 mem_ready  input  1  memory handshake; high = the current instruction or data access completes this cycle.
REQ-007 IMemRead  output  1  instruction-fetch request.
REQ-008 PCWrite, IRWrite  output  1 each  load PC+4 and load the instruction register.
REQ-009 Reg2Loc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc  output  1 each  datapath controls.
REQ-010 ALUOp  output  2  ALU operation class.
REQ-011 state  output  4  current state encoding.
REQ-012 illegal  output  1  one-cycle pulse: the decoded opcode is unrecognised.
REQ-013 instr_count  output  CNT_W  count of retired instructions.

Function
REQ-014 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, ADDR=5, MEM_RD=6, WB_LD=7, MEM_WR=8, BRANCH=9; codes 10-15 are unreachable and SHALL recover to IDLE on the next edge.
REQ-015 Opcode classes, sampled in DECODE and held in an internal register until the instruction ends:
- R-type: opcode[10]=1, [7:4]=0101, [2:0]=000.
- LDUR: 11111000010.
- STUR: 11111000000.
- CBZ: opcode[10:3]=10110100.
- NOP: all zero.
- Any other value: illegal.
REQ-016 Transitions:
- IDLE -> FETCH when run=1.
- FETCH waits while mem_ready=0, then -> DECODE.
- DECODE -> EXEC_R (R-type), ADDR (LDUR/STUR), BRANCH (CBZ), or instruction end (NOP/illegal).
- EXEC_R -> WB_R.
- ADDR -> MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD waits while mem_ready=0, then -> WB_LD.
- MEM_WR waits while mem_ready=0, then -> instruction end.
REQ-017 Instruction end occurs on leaving WB_R, WB_LD, MEM_WR (with mem_ready=1), BRANCH, or DECODE for NOP/illegal; next state is FETCH if run=1, else IDLE.
REQ-018 Moore outputs per state; every unlisted control is 0:
- FETCH: IMemRead=1.
- DECODE: Reg2Loc=1 for LDUR/STUR/CBZ.
- EXEC_R: ALUOp=10.
- WB_R: ALUOp=10, RegWrite=1.
- ADDR: Reg2Loc=1, ALUSrc=1, ALUOp=00.
- MEM_RD: MemRead=1, ALUSrc=1.
- WB_LD: MemtoReg=1, RegWrite=1.
- MEM_WR: Reg2Loc=1, MemWrite=1, ALUSrc=1.
- BRANCH: Reg2Loc=1, Branch=1, ALUOp=01.
REQ-019 PCWrite and IRWrite SHALL equal (state==FETCH && mem_ready) combinationally; both are 0 in all other states.
REQ-020 Latency with mem_ready held high: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, NOP/illegal 2 (FETCH through end); each wait cycle adds 1.
REQ-021 illegal SHALL be high for exactly the DECODE cycle of an unrecognised opcode; the instruction is otherwise treated as NOP.
REQ-022 instr_count SHALL increment by 1 on every instruction end (NOP and illegal included) and wrap from all-ones to 0.
REQ-023 run is sampled only in IDLE and at instruction end; deasserting run mid-instruction SHALL NOT abort that instruction.
REQ-024 mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Reset
REQ-025 While rst_n=0, the block SHALL immediately force state=IDLE, instr_count=0, the class register to NOP, and all control outputs and illegal to 0, independent of clk.
REQ-026 Reset asserted mid-instruction (including in a memory wait) SHALL abandon the instruction; after release, FETCH is entered only when run=1.

Verification
REQ-027 Reset, run=1, mem_ready=1, opcode=10001011000 (ADD) -> states 1,2,3,4,1; RegWrite=1 only in WB_R; ALUOp=10 in EXEC_R and WB_R; instr_count=1.
REQ-028 LDUR (11111000010) with mem_ready=0 for 2 cycles in MEM_RD -> MEM_RD held 3 cycles, MemRead=1 throughout; WB_LD has MemtoReg=1 and RegWrite=1; total 7 cycles.
REQ-029 STUR (11111000000) -> MemWrite=1 only in MEM_WR; RegWrite never 1; CBZ (10110100xxx) -> BRANCH with Branch=1, ALUOp=01; 3 cycles.
REQ-030 opcode=11111111111 -> illegal high for 1 cycle in DECODE; next state FETCH; instr_count increments.
REQ-031 run dropped during EXEC_R -> WB_R completes, then IDLE with all controls 0; rst_n pulsed low in FETCH wait -> state=0 and instr_count=0 asynchronously.
REQ-032 Preload of CNT_W=4 counter to 15 via 15 NOPs, then one more NOP -> instr_count=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle controller and its datapath.
// The master drives run/opcode/mem_ready; the slave (controller) drives everything else.
interface multicycle_control_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [10:0]      opcode;
   logic             mem_ready;
   logic             IMemRead;
   logic             PCWrite;
   logic             IRWrite;
   logic             Reg2Loc;
   logic             Branch;
   logic             MemRead;
   logic             MemWrite;
   logic             MemtoReg;
   logic             RegWrite;
   logic             ALUSrc;
   logic [1:0]       ALUOp;
   logic [3:0]       state;
   logic             illegal;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output run, opcode, mem_ready,
      input  IMemRead, PCWrite, IRWrite, Reg2Loc, Branch, MemRead, MemWrite,
             MemtoReg, RegWrite, ALUSrc, ALUOp, state, illegal, instr_count
   );

   modport slave (
      input  run, opcode, mem_ready,
      output IMemRead, PCWrite, IRWrite, Reg2Loc, Branch, MemRead, MemWrite,
             MemtoReg, RegWrite, ALUSrc, ALUOp, state, illegal, instr_count
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle instruction-sequencing controller: Moore control outputs, memory
// wait handling, illegal-opcode flag and a retired-instruction counter.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | stopped, waiting for run
//   FETCH  | instruction fetch, waits on mem_ready
//   DECODE | classify opcode; NOP/illegal end here
//   EXEC_R | R-type ALU operation
//   WB_R   | R-type register write-back
//   ADDR   | LDUR/STUR address calculation
//   MEM_RD | data read, waits on mem_ready
//   WB_LD  | load write-back
//   MEM_WR | data write, waits on mem_ready
//   BRANCH | CBZ compare/branch
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_WB_R   = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_WB_LD  = 4'd7,
      S_MEM_WR = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      C_NOP = 3'd0,
      C_R   = 3'd1,
      C_LD  = 3'd2,
      C_ST  = 3'd3,
      C_CB  = 3'd4,
      C_ILL = 3'd5
   } cls_t;

   state_t           r_state;
   state_t           w_next;
   state_t           w_after;
   cls_t             r_cls;
   cls_t             w_dec;
   logic             w_end;
   logic [CNT_W-1:0] r_cnt;

   always_comb begin
      w_dec = C_ILL;
      if (bus.opcode == 11'b00000000000)
         w_dec = C_NOP;
      else if (bus.opcode == 11'b11111000010)
         w_dec = C_LD;
      else if (bus.opcode == 11'b11111000000)
         w_dec = C_ST;
      else if (bus.opcode[10:3] == 8'b10110100)
         w_dec = C_CB;
      else if (bus.opcode[10] && (bus.opcode[7:4] == 4'b0101) && (bus.opcode[2:0] == 3'b000))
         w_dec = C_R;
   end

   // Instruction boundary: the only points besides IDLE where run is sampled.
   always_comb begin
      w_end = 1'b0;
      case (r_state)
         S_DECODE: w_end = (w_dec == C_NOP) || (w_dec == C_ILL);
         S_WB_R,
         S_WB_LD,
         S_BRANCH: w_end = 1'b1;
         S_MEM_WR: w_end = bus.mem_ready;
         default:  w_end = 1'b0;
      endcase
   end

   assign w_after = bus.run ? S_FETCH : S_IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:   w_next = bus.run ? S_FETCH : S_IDLE;
         S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (w_dec)
               C_R:       w_next = S_EXEC_R;
               C_LD,
               C_ST:      w_next = S_ADDR;
               C_CB:      w_next = S_BRANCH;
               default:   w_next = w_after;
            endcase
         end
         S_EXEC_R: w_next = S_WB_R;
         S_ADDR:   w_next = (r_cls == C_LD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: w_next = bus.mem_ready ? S_WB_LD : S_MEM_RD;
         S_MEM_WR: w_next = bus.mem_ready ? w_after : S_MEM_WR;
         S_WB_R,
         S_WB_LD,
         S_BRANCH: w_next = w_after;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cls <= C_NOP;
         r_cnt <= '0;
      end else begin
         if (r_state == S_DECODE)
            r_cls <= w_dec;
         else if (w_end)
            r_cls <= C_NOP;
         if (w_end)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      bus.IMemRead = 1'b0;
      bus.Reg2Loc  = 1'b0;
      bus.Branch   = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.RegWrite = 1'b0;
      bus.ALUSrc   = 1'b0;
      bus.ALUOp    = 2'b00;
      case (r_state)
         S_FETCH:  bus.IMemRead = 1'b1;
         S_DECODE: bus.Reg2Loc  = (w_dec == C_LD) || (w_dec == C_ST) || (w_dec == C_CB);
         S_EXEC_R: bus.ALUOp    = 2'b10;
         S_WB_R: begin
            bus.ALUOp    = 2'b10;
            bus.RegWrite = 1'b1;
         end
         S_ADDR: begin
            bus.Reg2Loc  = 1'b1;
            bus.ALUSrc   = 1'b1;
         end
         S_MEM_RD: begin
            bus.MemRead  = 1'b1;
            bus.ALUSrc   = 1'b1;
         end
         S_WB_LD: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
         end
         S_MEM_WR: begin
            bus.Reg2Loc  = 1'b1;
            bus.MemWrite = 1'b1;
            bus.ALUSrc   = 1'b1;
         end
         S_BRANCH: begin
            bus.Reg2Loc  = 1'b1;
            bus.Branch   = 1'b1;
            bus.ALUOp    = 2'b01;
         end
         default: ;
      endcase
   end

   assign bus.PCWrite     = (r_state == S_FETCH) && bus.mem_ready;
   assign bus.IRWrite     = (r_state == S_FETCH) && bus.mem_ready;
   assign bus.illegal     = (r_state == S_DECODE) && (w_dec == C_ILL);
   assign bus.state       = r_state;
   assign bus.instr_count = r_cnt;

endmodule
